exec_trace_buffer: RTL
======================

# exec_trace_buffer

Parametrised, synthesizable execution-trace capture buffer for the 8-bit/16-bit-instruction computer and its wider successors. It watches the per-cycle commit view (pc, instr, memwrite, dataadr, writedata) and keeps the most recent DEPTH records in a circular buffer. It supports an optional store-address trigger with a configurable post-trigger window, then freezes the buffer and streams it out oldest-first over a valid/ready port. It sits beside the computer top level and replaces $monitor-style tracing with on-chip, bench-independent capture.

## Interface
- DWIDTH, 8, data/address width of writedata and dataadr
- IWIDTH, 16, instruction width
- PCWIDTH, 8, program-counter width
- DEPTH, 16, buffer entries; power of two, at least 2
- POST_TRIG, 8, records captured after the trigger record; 0 to DEPTH-1
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  one-cycle pulse; clears the buffer and enters ARMED
- stop  in  1  forces capture to end (ARMED/POST -> DONE)
- wr_only  in  1  1 = capture only cycles with memwrite=1
- trig_en  in  1  enables the store-address trigger
- trig_addr  in  DWIDTH  trigger address
- valid  in  1  the current cycle's commit record is meaningful
- pc, instr, memwrite, dataadr, writedata  in  PCWIDTH/IWIDTH/1/DWIDTH/DWIDTH  commit record
- rd_valid  out  1  rd_data holds an unread record
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  PCWIDTH+IWIDTH+2*DWIDTH+1  packed record {pc, instr, memwrite, dataadr, writedata}, pc in MSBs
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- triggered  out  1  trigger fired since last arm
- overflow  out  1  at least one entry overwritten since last arm
- count  out  $clog2(DEPTH)+1  entries held (capture) / entries unread (DONE)

## Operation
- A cycle is capturable when valid=1 and (wr_only=0 or memwrite=1). In ARMED/POST, a capturable cycle writes the record at wr_ptr, wr_ptr increments mod DEPTH, count saturates at DEPTH. A write while count=DEPTH sets overflow.
- Trigger hit: state ARMED, trig_en=1, capturable, memwrite=1, dataadr==trig_addr. The hit record is stored and triggered is set. If POST_TRIG=0 go to DONE; else go to POST with post_cnt=POST_TRIG.
- POST: each capture decrements post_cnt. The capture that takes it to 0 moves the block to DONE.
- stop in ARMED/POST: the current cycle's capturable record is still stored (and may still set triggered), then go to DONE. stop has priority over the POST countdown. stop in IDLE or DONE is ignored.
- arm, in any state, has priority over everything else. It clears wr_ptr, count, triggered, overflow and post_cnt and enters ARMED. The arming cycle itself is not captured.
- DONE: the read pointer starts at (wr_ptr - count) mod DEPTH. rd_valid = (count != 0). A transfer (rd_valid & rd_ready) advances the read pointer and decrements count. The transfer that empties the buffer returns the block to IDLE on the same edge. DONE entered with count=0 goes to IDLE next cycle.
- IDLE: no capture. rd_valid=0.
- rd_data is forced to 0 whenever rd_valid=0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, triggered=0, overflow=0, count=0, rd_valid=0, rd_data=0, all pointers 0. Buffer contents are not cleared.
- Capture latency: a record presented at edge N is held in the buffer after edge N. count updates on edge N.
- State transitions take effect on the edge where their condition is sampled.
- rd_data and rd_valid are combinational from the registered read pointer and count, so the first record is available the cycle after DONE is entered. Read throughput is one record per cycle with rd_ready held high.
- Reset asserted mid-capture or mid-read aborts immediately. No partial state survives.

## Test plan
- Reset mid-POST: arm, trigger, assert reset=0 during POST -> all outputs at reset values asynchronously, before the next clk edge.
- DEPTH=16, POST_TRIG=8: arm, 30 valid cycles with pc=0..29, no trigger, then stop -> DONE, count=16, overflow=1; readout gives pc 14..29 in order, then IDLE.
- trig_addr=0x40: store to 0x40 at pc=5, with valid every cycle from pc=0 -> POST; DONE after pc=13; readout gives pc 0..13 (14 records), triggered=1, overflow=0.
- wr_only=1: 20 cycles with memwrite=1 only at pc=3,7,11; stop -> count=3; records show dataadr/writedata of exactly those stores.
- POST_TRIG=0 with stop asserted on the trigger cycle -> one DONE transition, trigger record is the last one read, triggered=1. Separately: arm during DONE readout with 5 unread -> ARMED, count=0, rd_valid=0 next cycle.
- rd_ready toggling 1,0,1,0 -> each record emitted exactly once, rd_data stable while rd_valid=1 and rd_ready=0.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer
// Execution-trace capture buffer for the instruction computer's commit view.
// Keeps the most recent DEPTH commit records in a circular buffer. An optional
// store-address trigger, followed by a post-trigger window, ends the capture.
// An explicit stop also ends it. The frozen buffer is then streamed out
// oldest-first over a valid/ready port.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   arm               one-cycle pulse: clear the capture state and enter ARMED
//   stop              end the capture now (ARMED/POST -> DONE)
//   wr_only           capture only the cycles where memwrite=1
//   trig_en/trig_addr store-address trigger enable and address
//   valid, pc, instr, memwrite, dataadr, writedata
//                     per-cycle commit record
//   rd_valid/rd_ready/rd_data
//                     readout stream {pc, instr, memwrite, dataadr, writedata}
//   state, triggered, overflow, count
//                     status outputs
module exec_trace_buffer #(
  parameter int DWIDTH    = 8,
  parameter int IWIDTH    = 16,
  parameter int PCWIDTH   = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  arm,
  input  logic                                  stop,
  input  logic                                  wr_only,
  input  logic                                  trig_en,
  input  logic [DWIDTH-1:0]                     trig_addr,
  input  logic                                  valid,
  input  logic [PCWIDTH-1:0]                    pc,
  input  logic [IWIDTH-1:0]                     instr,
  input  logic                                  memwrite,
  input  logic [DWIDTH-1:0]                     dataadr,
  input  logic [DWIDTH-1:0]                     writedata,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic [PCWIDTH+IWIDTH+2*DWIDTH:0]      rd_data,
  output logic [1:0]                            state,
  output logic                                  triggered,
  output logic                                  overflow,
  output logic [$clog2(DEPTH):0]                count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = PCWIDTH + IWIDTH + 2*DWIDTH + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          triggered_q, triggered_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;

  logic [RW-1:0] mem [DEPTH];

  logic          capturable;
  logic          trig_hit;
  logic [RW-1:0] rec_in;

  assign capturable = valid && (!wr_only || memwrite);
  assign trig_hit   = (state_q == ST_ARMED) && trig_en && capturable && memwrite &&
                      (dataadr == trig_addr);
  assign rec_in     = {pc, instr, memwrite, dataadr, writedata};

  assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
  assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

  // Next-state logic. arm overrides everything. In ARMED/POST the capture is
  // applied first, and then stop can still force DONE. The read pointer is
  // loaded with the oldest entry using the post-capture pointer and count.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;

    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (capturable) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == FULL) begin
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (trig_hit) begin
              triggered_d = 1'b1;
              if (POST_TRIG == 0) begin
                state_d = ST_DONE;
              end else begin
                state_d    = ST_POST;
                post_cnt_d = POST_INIT;
              end
            end else if (state_q == ST_POST) begin
              post_cnt_d = post_cnt_q - AW'(1);
              if (post_cnt_q == AW'(1)) begin
                state_d = ST_DONE;
              end
            end
          end
          if (stop) begin
            state_d = ST_DONE;
          end
          if (state_d == ST_DONE) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
          end
        end
        ST_DONE: begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  // Record storage has no reset. Reset clears only the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rec_in;
    end
  end

endmodule
